vec_load_writeback: RTL and testbench
=====================================

Name: vec_load_writeback

Overview:
- Sequencer that fetches a scalar word or a full 16-lane vector from data memory, one 32-bit word per request, and assembles it in a lane buffer.
- Issues a single register-file write with the vector/scalar select driven accordingly.
- Sits between the load/store stage and the register file write port (we, waddr, wdata, sel_v_s_w). It is the writer side of that port.

Parameters:
- LANES, 16, vector lanes; lane 15 is the scalar lane.
- DW, 32, data word width.
- RAW, 4, register address width.
- MAW, 32, memory byte-address width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  load request, sampled only in IDLE.
- is_vector  in  1  1 = vector load (16 words), 0 = scalar load (1 word).
- dest_reg  in  RAW  destination register index.
- base_addr  in  MAW  byte address of lane 0 (vector) or of the word (scalar).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse coincident with rf_we, or with err.
- err  out  1  one-cycle pulse when a request is rejected.
- mem_req  out  1  one-cycle read request pulse.
- mem_addr  out  MAW  read address, valid while mem_req is high.
- mem_rdata  in  DW  read data.
- mem_rvalid  in  1  read data valid; at most one per mem_req; earliest one cycle after mem_req.
- rf_we  out  1  register-file write enable, one cycle.
- rf_waddr  out  RAW  destination register.
- rf_wdata  out  LANES*DW  packed lanes [15:0][31:0].
- rf_sel_v_s_w  out  1  1 = vector write, 0 = scalar write (scalar data on lane 15).
- load_count  out  32  number of completed register-file writes; wraps modulo 2^32.

Behaviour:
- Reset values:
  - busy, done, err, mem_req, rf_we, rf_sel_v_s_w = 0.
  - mem_addr, rf_waddr, rf_wdata, load_count = 0.
  - State is IDLE and the lane buffer is all zero.
  - Reset asserted mid-operation aborts the load immediately. No rf_we is issued and the partial buffer is cleared.
- All outputs are driven from flops; there are no combinational paths from inputs to outputs. The register file samples on negedge, so outputs are stable from posedge through the following negedge.
- State machine: IDLE -> ISSUE -> WAIT -> (ISSUE | WB) -> IDLE; a rejected start goes IDLE -> REJECT -> IDLE.
- IDLE:
  - On start: latch is_vector, dest_reg and base_addr; clear the lane buffer.
  - Set lane index to 0 for a vector load or 15 for a scalar load.
  - Next state is ISSUE, or REJECT for a scalar load with dest_reg == 15. The scalar bank has only 15 entries and r15 is the PC.
  - A vector load to dest 15 is legal.
- REJECT: err = 1 and done = 1 for one cycle, with no memory or register-file activity. Next state is IDLE.
- ISSUE:
  - mem_req = 1.
  - mem_addr = base + 4*lane for a vector load, or base for a scalar load. Address arithmetic is modulo 2^MAW.
  - Next state is WAIT.
- WAIT:
  - Hold until mem_rvalid, then write mem_rdata into buf[lane].
  - If the load is scalar, or lane == 15, go to WB. Otherwise increment lane and go to ISSUE.
- WB:
  - rf_we = 1, rf_waddr = dest, rf_sel_v_s_w = is_vector, rf_wdata = buf, done = 1.
  - load_count increments.
  - Next state is IDLE.
  - For a scalar load only lane 15 is meaningful; lanes 0..14 are 0.
- start while busy is ignored; it is neither queued nor treated as an error.
- mem_rvalid outside WAIT is ignored, and the buffer is unchanged.
- rf_wdata holds its last value after WB. rf_we is the only qualifier.
- Latency, with memory latency L (rvalid L >= 1 cycles after mem_req) and start accepted at edge 0:
  - Each word takes L+1 cycles.
  - A vector load asserts rf_we in cycle 16*(L+1)+1.
  - A scalar load asserts rf_we in cycle L+2.
  - A rejected start pulses err in cycle 1.
- Throughput: one load in flight; one outstanding memory request at a time.

Decomposition:
- Package vlw_pkg contains:
  - LANES, DW, RAW, MAW constants.
  - typedef vec_t = logic [LANES-1:0][DW-1:0].
  - State enum {IDLE, ISSUE, WAIT, WB, REJECT}.
  - SCALAR_LANE = 15 and PC_REG = 15.
- Sub-module vlw_lane_buffer: a 16x32 buffer with synchronous clear, single-lane write (lane index, data, enable) and full-vector read. The FSM, address generation and counter stay in the top level.

Test Plan:
- Vector load, L=1, base 0x100, mem word i = i+1, dest 3:
  - mem_addr steps 0x100, 0x104 ... 0x13C.
  - rf_we in cycle 33 with rf_sel_v_s_w=1, rf_waddr=3, lane i = i+1.
  - done with rf_we; load_count=1.
- Scalar load, L=3, base 0x20, rdata 0xDEADBEEF, dest 8:
  - Single mem_req with addr 0x20.
  - rf_we in cycle 5, rf_sel_v_s_w=0, lane15=0xDEADBEEF, lanes 0..14 = 0.
- Scalar load to dest 15:
  - err and done in cycle 1.
  - No mem_req, no rf_we, load_count unchanged.
- Protocol abuse:
  - start pulsed mid-vector-load is ignored.
  - Stray mem_rvalid during ISSUE is ignored.
  - Completed vector data is identical to the clean run.
- Reset during WAIT of lane 7:
  - All outputs 0 at once; no rf_we.
  - A following scalar load completes normally with lanes 0..14 = 0.
- Base 0xFFFFFFF8 vector load: mem_addr wraps to 0x00000000 at lane 2.

Source files
------------

// File: rtl/vlw_pkg.sv
// Shared constants and types for the vector/scalar load writeback sequencer.
package vlw_pkg;
   localparam int LANES = 16;
   localparam int DW    = 32;
   localparam int RAW   = 4;
   localparam int MAW   = 32;
   localparam int LW    = $clog2(LANES);

   localparam logic [LW-1:0]  SCALAR_LANE = LW'(15);
   localparam logic [RAW-1:0] PC_REG      = RAW'(15);

   typedef logic [LANES-1:0][DW-1:0] vec_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      WB,
      REJECT
   } state_t;
endpackage

// File: rtl/vlw_lane_buffer.sv
// 16x32 lane buffer: synchronous clear, single-lane write, full-vector read.
module vlw_lane_buffer
   import vlw_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        wr_en,
   input  logic [LW-1:0]               wr_lane,
   input  logic [DW-1:0]               wr_data,
   output logic [LANES-1:0][DW-1:0]    rd_vec
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rd_vec <= '0;
      else if (clr)
         rd_vec <= '0;
      else if (wr_en)
         rd_vec[wr_lane] <= wr_data;
   end

endmodule

// File: rtl/vec_load_writeback.sv
// Fetches one word or a 16-lane vector from memory, one word per request,
// then issues a single register-file write.
module vec_load_writeback
   import vlw_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     is_vector,
   input  logic [RAW-1:0]           dest_reg,
   input  logic [MAW-1:0]           base_addr,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     mem_req,
   output logic [MAW-1:0]           mem_addr,
   input  logic [DW-1:0]            mem_rdata,
   input  logic                     mem_rvalid,
   output logic                     rf_we,
   output logic [RAW-1:0]           rf_waddr,
   output logic [LANES*DW-1:0]      rf_wdata,
   output logic                     rf_sel_v_s_w,
   output logic [31:0]              load_count
);

   state_t          state;
   logic            vec_q;
   logic [RAW-1:0]  dest_q;
   logic [MAW-1:0]  base_q;
   logic [LW-1:0]   lane;
   logic [LW-1:0]   lane_inc;
   vec_t            buf_vec;
   logic            buf_clr;
   logic            buf_wr;

   assign lane_inc = lane + LW'(1);
   assign buf_clr  = (state == IDLE) && start;
   assign buf_wr   = (state == WAIT) && mem_rvalid;

   vlw_lane_buffer u_buf (
      .clk     (clk),
      .rst     (rst),
      .clr     (buf_clr),
      .wr_en   (buf_wr),
      .wr_lane (lane),
      .wr_data (mem_rdata),
      .rd_vec  (buf_vec)
   );

   // mem_req/mem_addr are registered on entry to ISSUE, so the request is
   // visible during the ISSUE cycle itself; rf_we is registered on leaving WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         vec_q        <= 1'b0;
         dest_q       <= '0;
         base_q       <= '0;
         lane         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         mem_req      <= 1'b0;
         mem_addr     <= '0;
         rf_we        <= 1'b0;
         rf_waddr     <= '0;
         rf_wdata     <= '0;
         rf_sel_v_s_w <= 1'b0;
         load_count   <= '0;
      end else begin
         mem_req <= 1'b0;
         rf_we   <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  vec_q  <= is_vector;
                  dest_q <= dest_reg;
                  base_q <= base_addr;
                  lane   <= is_vector ? '0 : SCALAR_LANE;
                  busy   <= 1'b1;
                  if (!is_vector && dest_reg == PC_REG) begin
                     state <= REJECT;
                  end else begin
                     state    <= ISSUE;
                     mem_req  <= 1'b1;
                     mem_addr <= base_addr;
                  end
               end
            end
            REJECT: begin
               err   <= 1'b1;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            ISSUE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (mem_rvalid) begin
                  if (!vec_q || lane == SCALAR_LANE) begin
                     state <= WB;
                  end else begin
                     lane     <= lane_inc;
                     mem_addr <= base_q + {{(MAW-LW-2){1'b0}}, lane_inc, 2'b00};
                     mem_req  <= 1'b1;
                     state    <= ISSUE;
                  end
               end
            end
            WB: begin
               rf_we        <= 1'b1;
               rf_waddr     <= dest_q;
               rf_sel_v_s_w <= vec_q;
               rf_wdata     <= buf_vec;
               done         <= 1'b1;
               busy         <= 1'b0;
               load_count   <= load_count + 32'd1;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vec_load_writeback.sv
// Self-checking bench: table of loads plus reset/abuse sequences, with a
// scoreboard for memory addresses and register-file writes.
module tb_vec_load_writeback;
   import vlw_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             is_vector;
   logic [RAW-1:0]   dest_reg;
   logic [MAW-1:0]   base_addr;
   logic             busy, done, err, mem_req, rf_we, rf_sel_v_s_w;
   logic [MAW-1:0]   mem_addr;
   logic [DW-1:0]    mem_rdata;
   logic             mem_rvalid;
   logic [RAW-1:0]   rf_waddr;
   logic [LANES*DW-1:0] rf_wdata;
   logic [31:0]      load_count;

   vec_load_writeback dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .is_vector    (is_vector),
      .dest_reg     (dest_reg),
      .base_addr    (base_addr),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_rdata    (mem_rdata),
      .mem_rvalid   (mem_rvalid),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .rf_sel_v_s_w (rf_sel_v_s_w),
      .load_count   (load_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   task automatic chk(input string name, input logic [LANES*DW-1:0] act,
                      input logic [LANES*DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // memory model state
   logic [MAW-1:0] mem_base;
   logic           vec_mode;
   logic [DW-1:0]  scalar_val;
   int             lat;
   logic           stray_en;
   int             cnt;
   logic [MAW-1:0] req_addr;
   int             req_seen;

   function automatic logic [DW-1:0] mem_word(input logic [MAW-1:0] a);
      logic [MAW-1:0] off;
      off = a - mem_base;
      return vec_mode ? (off >> 2) + 32'd1 : scalar_val;
   endfunction

   always @(negedge clk) begin
      mem_rvalid <= 1'b0;
      if (rst) begin
         cnt <= 0;
      end else begin
         if (stray_en && mem_req) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= 32'hBAD0BAD0;
         end
         if (cnt == 1) begin
            mem_rvalid <= 1'b1;
            mem_rdata  <= mem_word(req_addr);
         end
         if (cnt > 0) cnt <= cnt - 1;
         if (mem_req) begin
            req_addr <= mem_addr;
            cnt      <= lat;
         end
      end
   end

   // scoreboard
   typedef struct {
      logic [RAW-1:0] waddr;
      logic           sel;
      vec_t           data;
   } rf_exp_t;

   logic [MAW-1:0] exp_addr_q[$];
   rf_exp_t        exp_rf_q[$];

   always @(negedge clk) begin
      if (!rst && mem_req) begin
         req_seen <= req_seen + 1;
         if (exp_addr_q.size() == 0)
            chk("unexpected_mem_req", {480'd0, mem_addr}, '1);
         else
            chk("mem_addr", {480'd0, mem_addr}, {480'd0, exp_addr_q.pop_front()});
      end
      if (!rst && rf_we) begin
         if (exp_rf_q.size() == 0) begin
            chk("unexpected_rf_we", 512'd1, 512'd0);
         end else begin
            rf_exp_t e;
            e = exp_rf_q.pop_front();
            chk("rf_waddr", {508'd0, rf_waddr}, {508'd0, e.waddr});
            chk("rf_sel", {511'd0, rf_sel_v_s_w}, {511'd0, e.sel});
            chk("rf_wdata", rf_wdata, e.data);
         end
      end
   end

   typedef struct {
      logic           isv;
      logic [RAW-1:0] dest;
      logic [MAW-1:0] base;
      int             lat;
      logic [DW-1:0]  sval;
      logic           rej;
      int             exp_cyc;
   } rec_t;

   rec_t tbl[6];
   int   lc_model = 0;

   task automatic run_load(input rec_t r, input bit abuse);
      int n;
      rf_exp_t e;
      mem_base = r.base; vec_mode = r.isv; scalar_val = r.sval; lat = r.lat;
      if (!r.rej) begin
         for (int i = 0; i < (r.isv ? 16 : 1); i++)
            exp_addr_q.push_back(r.base + 32'(4 * i));
         e.waddr = r.dest;
         e.sel   = r.isv;
         e.data  = '0;
         if (r.isv)
            for (int i = 0; i < LANES; i++) e.data[i] = 32'(i + 1);
         else
            e.data[15] = r.sval;
         exp_rf_q.push_back(e);
         lc_model++;
      end
      start = 1'b1; is_vector = r.isv; dest_reg = r.dest; base_addr = r.base;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      chk("busy_cycle0", {511'd0, busy}, 512'd1);
      stray_en = abuse;
      while (!done && n < 400) begin
         @(posedge clk); #1;
         n++;
         if (abuse && n == 5) begin
            start = 1'b1; is_vector = 1'b0; dest_reg = 4'd15; base_addr = 32'h5555;
         end
         if (abuse && n == 6) start = 1'b0;
      end
      stray_en = 1'b0;
      chk("done_latency", 512'(n), 512'(r.exp_cyc));
      chk("err_at_done", {511'd0, err}, {511'd0, r.rej});
      chk("rf_we_at_done", {511'd0, rf_we}, {511'd0, !r.rej});
      @(posedge clk); #1;
      chk("load_count", {480'd0, load_count}, 512'(lc_model));
      chk("idle_after", {509'd0, busy, done, rf_we}, 512'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; is_vector = 1'b0; dest_reg = '0; base_addr = '0;
      stray_en = 1'b0; lat = 1; mem_base = '0; vec_mode = 1'b0; scalar_val = '0;
      req_seen = 0; cnt = 0; mem_rdata = '0;

      tbl[0] = '{1'b1, 4'd3,  32'h0000_0100, 1, 32'h0,         1'b0, 33};
      tbl[1] = '{1'b0, 4'd8,  32'h0000_0020, 3, 32'hDEADBEEF,  1'b0, 5};
      tbl[2] = '{1'b0, 4'd15, 32'h0000_0040, 1, 32'h11111111,  1'b1, 1};
      tbl[3] = '{1'b1, 4'd15, 32'hFFFF_FFF8, 2, 32'h0,         1'b0, 49};
      tbl[4] = '{1'b0, 4'd0,  32'h0000_0007, 1, 32'h12345678,  1'b0, 3};
      tbl[5] = '{1'b1, 4'd7,  32'h0000_1000, 4, 32'h0,         1'b0, 81};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_ctrl", {506'd0, busy, done, err, mem_req, rf_we, rf_sel_v_s_w}, 512'd0);
      chk("reset_mem_addr", {480'd0, mem_addr}, 512'd0);
      chk("reset_wdata", rf_wdata, 512'd0);
      chk("reset_count", {480'd0, load_count}, 512'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++) run_load(tbl[i], 1'b0);

      // start mid-load and stray rvalid during ISSUE must not disturb data
      run_load(tbl[0], 1'b1);

      // reset during WAIT of lane 7
      begin
         int n, r0;
         r0 = req_seen;
         mem_base = 32'h200; vec_mode = 1'b1; lat = 2;
         for (int i = 0; i < 8; i++) exp_addr_q.push_back(32'h200 + 32'(4 * i));
         start = 1'b1; is_vector = 1'b1; dest_reg = 4'd4; base_addr = 32'h200;
         @(posedge clk); #1;
         start = 1'b0;
         n = 0;
         while (req_seen < r0 + 8 && n < 400) begin
            @(posedge clk); #1; n++;
         end
         chk("reach_lane7", 512'(req_seen - r0), 512'd8);
         rst = 1'b1;
         #1;
         chk("abort_ctrl", {506'd0, busy, done, err, mem_req, rf_we, rf_sel_v_s_w}, 512'd0);
         chk("abort_mem_addr", {480'd0, mem_addr}, 512'd0);
         chk("abort_waddr", {508'd0, rf_waddr}, 512'd0);
         chk("abort_wdata", rf_wdata, 512'd0);
         chk("abort_count", {480'd0, load_count}, 512'd0);
         lc_model = 0;
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b0;
         @(posedge clk); #1;
         run_load('{1'b0, 4'd2, 32'h300, 2, 32'hCAFEF00D, 1'b0, 4}, 1'b0);
      end

      repeat (3) @(posedge clk);
      chk("addr_q_empty", 512'(exp_addr_q.size()), 512'd0);
      chk("rf_q_empty", 512'(exp_rf_q.size()), 512'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
